// File: rtl/exe_ctrl_update_queue_if.sv
// Bundle of the two handshake sides of the control-update queue.
//   exeCtrl*_i : resolved CTI from the control execution pipe (no backpressure)
//   updReady_i : predictor/BTB update port accepts the head entry
//   upd*_o     : head entry presented to the predictor update port
// slave  = queue side, master = producer/consumer side (bench or core glue).
interface exe_ctrl_update_queue_if #(
    parameter int PC_W   = 32,
    parameter int TYPE_W = 2,
    parameter int CTI_W  = 4
);
    logic              exeCtrlValid_i;
    logic [PC_W-1:0]   exeCtrlPC_i;
    logic [PC_W-1:0]   exeCtrlNPC_i;
    logic [TYPE_W-1:0] exeCtrlType_i;
    logic              exeCtrlDir_i;
    logic [CTI_W-1:0]  exeCtiID_i;
    logic              updReady_i;
    logic              updValid_o;
    logic [PC_W-1:0]   updPC_o;
    logic [PC_W-1:0]   updNPC_o;
    logic [TYPE_W-1:0] updType_o;
    logic              updDir_o;
    logic [CTI_W-1:0]  updCtiID_o;

    modport slave (
        input  exeCtrlValid_i, exeCtrlPC_i, exeCtrlNPC_i, exeCtrlType_i,
               exeCtrlDir_i, exeCtiID_i, updReady_i,
        output updValid_o, updPC_o, updNPC_o, updType_o, updDir_o, updCtiID_o
    );

    modport master (
        output exeCtrlValid_i, exeCtrlPC_i, exeCtrlNPC_i, exeCtrlType_i,
               exeCtrlDir_i, exeCtiID_i, updReady_i,
        input  updValid_o, updPC_o, updNPC_o, updType_o, updDir_o, updCtiID_o
    );
endinterface

// File: rtl/exe_ctrl_update_queue.sv
// In-order queue between the control execution pipe and the branch
// predictor/BTB update port. The execution pipe cannot stall, so pushes that
// find the queue full (and no pop in the same cycle) are dropped and counted.
// Ports:
//   clk, reset   : core clock, asynchronous active-low reset
//   flush_i      : synchronous clear of all entries (drop counter kept)
//   q_if         : exeCtrl* push side and upd* drain side (slave modport)
//   count_o      : registered occupancy 0..DEPTH
//   dropCnt_o    : registered saturating count of dropped pushes
module exe_ctrl_update_queue #(
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 16,
    parameter int PC_W       = 32,
    parameter int TYPE_W     = 2,
    parameter int CTI_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    exe_ctrl_update_queue_if.slave    q_if,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DROP_CNT_W-1:0]     dropCnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [TYPE_W-1:0] typ;
        logic              dir;
        logic [CTI_W-1:0]  cti;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic   push, pop, full, push_ok, drop;
    entry_t wdata, head;

    // flush masks both events, so a push during flush is neither stored nor
    // counted as a drop.
    assign push    = q_if.exeCtrlValid_i & ~flush_i;
    assign pop     = (count_q != '0) & q_if.updReady_i & ~flush_i;
    assign full    = (count_q == CNT_W'(DEPTH));
    // When full, a same-cycle pop frees the slot the push writes into.
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;

    assign wdata = '{pc:  q_if.exeCtrlPC_i,
                     npc: q_if.exeCtrlNPC_i,
                     typ: q_if.exeCtrlType_i,
                     dir: q_if.exeCtrlDir_i,
                     cti: q_if.exeCtiID_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
            if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage is data-only; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign head = mem_q[rd_ptr_q];

    assign q_if.updValid_o = (count_q != '0);
    assign q_if.updPC_o    = head.pc;
    assign q_if.updNPC_o   = head.npc;
    assign q_if.updType_o  = head.typ;
    assign q_if.updDir_o   = head.dir;
    assign q_if.updCtiID_o = head.cti;

    assign count_o   = count_q;
    assign dropCnt_o = drop_q;
endmodule

// File: doc/exe_ctrl_update_queue.md
# exe_ctrl_update_queue

Buffers resolved control-transfer outcomes from the control execution pipe and drains them in order to the branch-predictor/BTB update port. Input comes from the control pipe's writeback outputs: exeCtrlPC, Type, Valid, NPC, Dir and CtiID. The predictor side may stall, but the execution pipe cannot. The queue therefore absorbs bursts and drops entries on overflow, counting each drop.

## Interface
- DEPTH, 8, number of entries; must be a power of 2, ≥2
- DROP_CNT_W, 16, width of the saturating drop counter
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous clear of all entries (context switch / predictor reset)
- exeCtrlValid_i  input  1  resolved CTI present this cycle
- exeCtrlPC_i  input  `SIZE_PC  PC of the CTI
- exeCtrlNPC_i  input  `SIZE_PC  resolved target/next PC
- exeCtrlType_i  input  `BRANCH_TYPE  CTI type
- exeCtrlDir_i  input  1  resolved direction (1 = taken)
- exeCtiID_i  input  `SIZE_CTI_LOG  CTI queue ID
- updReady_i  input  1  predictor accepts the head entry this cycle
- updValid_o  output  1  head entry valid
- updPC_o  output  `SIZE_PC  head PC
- updNPC_o  output  `SIZE_PC  head NPC
- updType_o  output  `BRANCH_TYPE  head type
- updDir_o  output  1  head direction
- updCtiID_o  output  `SIZE_CTI_LOG  head CTI ID
- count_o  output  log2(DEPTH)+1  current occupancy
- dropCnt_o  output  DROP_CNT_W  saturating count of dropped pushes

## Operation
- Storage: circular buffer of DEPTH entries. Read and write pointers are each log2(DEPTH) bits and wrap naturally. Occupancy is held in a counter register 0..DEPTH.
- Push event: exeCtrlValid_i=1 and flush_i=0.
- Pop event: updValid_o=1, updReady_i=1 and flush_i=0.
- Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Otherwise the push is dropped: no state changes except dropCnt_o. dropCnt_o increments by 1 and saturates at all-ones.
- Count update rules:
  - accepted push with no pop: count+1
  - pop with no push: count-1
  - push and pop together: count unchanged
- Entries leave in push order. An entry is never reordered or coalesced.
- updValid_o = (count≠0). The upd*_o fields are driven combinationally from the entry at the read pointer. When updValid_o=0 the fields hold don't-care values; the bench must not check them.
- flush_i, in the cycle it is asserted:
  - has priority over push and pop
  - clears count and both pointers next cycle
  - any push or pop in that cycle is ignored and is not counted as a drop
  - dropCnt_o is preserved
- Reset (reset=0, at any time, including mid-burst or mid-drain):
  - pointers and count go to 0, dropCnt_o goes to 0
  - updValid_o=0 and count_o=0 immediately (asynchronous)
  - entry storage is not reset
- updReady_i while updValid_o=0 has no effect.

## Timing
- Push to visibility: an entry pushed at clock edge N into an empty queue appears on updValid_o/upd*_o after edge N, i.e. one cycle of latency. There is no combinational path from exeCtrl*_i to upd*_o.
- A pop at edge N presents the next entry immediately after edge N.
- Sustained throughput: 1 push and 1 pop per cycle.
- count_o and dropCnt_o are registered and reflect events from the previous edge.
- Outputs immediately after reset release: updValid_o=0, count_o=0, dropCnt_o=0.

## Test plan
- Basic in-order drain: push PCs 0x100, 0x104, 0x108 on consecutive cycles with updReady_i=0, then raise updReady_i. Expect updPC_o sequence 0x100, 0x104, 0x108, then updValid_o=0. count_o goes 3,2,1,0.
- Overflow with DEPTH=8: push 10 entries with updReady_i=0. Expect count_o=8 and dropCnt_o=2, and the head is the first entry pushed.
- Full with simultaneous push and pop: count=8, updReady_i=1, push PC 0x200 in the same cycle. Expect the push accepted, count_o stays 8, dropCnt_o unchanged, and 0x200 is the 8th entry to drain.
- Pointer wrap: stream 20 pushes with updReady_i=1 every cycle. Expect 20 pops in order, no drops, and count_o ≤1 throughout.
- Flush with a coincident push: count=5, assert flush_i together with exeCtrlValid_i. Next cycle expect count_o=0, updValid_o=0 and dropCnt_o unchanged. A later push of PC 0x300 then appears as the head.
- Async reset mid-drain: with count=4, assert reset low between clock edges. Expect updValid_o=0, count_o=0 and dropCnt_o=0 without waiting for a clock edge. After release, the first push appears after one edge.
